// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction-fetch unit.
package ifu_pkg;

    localparam int IFU_ADDR_W          = 32;
    localparam int IFU_MAX_OUTSTANDING = 2;
    localparam int IFU_BUF_DEPTH       = 2;

    // Fetch-controller states: normal issue, draining killed fetches, halted on bus error.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_KILL = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // One instruction-buffer entry as presented to the IR stage.
    typedef struct packed {
        logic [31:0]           instr;
        logic [IFU_ADDR_W-1:0] pc;
        logic                  err;
    } ifu_buf_entry_t;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Bundle of PC-generator, flush, memory-port and IR-stage signals around the fetch controller.
//
// Handshake rules: a transfer happens on a rising clk edge where the producer's valid and the
// consumer's ready/accept are both high. pcg_accept is the PC generator's ready and is the
// same-cycle copy of the memory issue. Memory responses have no ready: every mem_rsp_vld
// cycle is consumed. ir_vld/ir_rdy pop one buffer entry per handshake cycle.
interface ifu_fetch_ctrl_if #(
    parameter int ADDR_W = ifu_pkg::IFU_ADDR_W
);
    logic              pcg_req_vld;
    logic [ADDR_W-1:0] pcg_pc;
    logic              pcg_accept;
    logic              exe_flush;
    logic              int_flush;
    logic              mem_req_vld;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_rdy;
    logic              mem_rsp_vld;
    logic [31:0]       mem_rsp_data;
    logic              mem_rsp_err;
    logic              ir_vld;
    logic [31:0]       ir_instr;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_err;
    logic              ir_rdy;

    // Fetch controller side.
    modport master (
        input  pcg_req_vld, pcg_pc, exe_flush, int_flush,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_data, mem_rsp_err, ir_rdy,
        output pcg_accept, mem_req_vld, mem_req_addr,
        output ir_vld, ir_instr, ir_pc, ir_err
    );

    // Environment side: PC generator, memory port and IR stage.
    modport slave (
        output pcg_req_vld, pcg_pc, exe_flush, int_flush,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_data, mem_rsp_err, ir_rdy,
        input  pcg_accept, mem_req_vld, mem_req_addr,
        input  ir_vld, ir_instr, ir_pc, ir_err
    );
endinterface

// File: rtl/ifu_sync_fifo.sv
// Small synchronous FIFO with synchronous clear and an occupancy count.
// Pop on empty and push on full (without a same-cycle pop) are ignored.
module ifu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Qualify requests against occupancy; a full FIFO may push only while popping.
    always_comb begin
        do_pop  = pop & (count_q != '0);
        do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and count; clear wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch controller: issues in-order instruction fetches under a credit limit, remembers
// the PC of each in-flight request, buffers returned words for the IR stage, discards
// responses belonging to fetches killed by a flush and stops fetching after a bus error.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = IFU_MAX_OUTSTANDING,
    parameter int BUF_DEPTH       = IFU_BUF_DEPTH,
    parameter int ADDR_W          = IFU_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    ifu_fetch_ctrl_if.master                 bus,
    output fetch_state_e                     dbg_state,
    output logic [$clog2(MAX_OUTSTANDING):0] dbg_outstanding,
    output logic [$clog2(MAX_OUTSTANDING):0] dbg_kill_cnt
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = $bits(ifu_buf_entry_t);

    fetch_state_e   state_q, state_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [OW-1:0]  kill_q, kill_d;

    logic           flush;
    logic           credit_ok;
    logic           issue;
    logic           rsp_fire;
    logic           rsp_keep;
    logic           ir_pop;

    logic [ADDR_W-1:0] rsp_pc;
    logic [OW-1:0]     pcf_count;
    ifu_buf_entry_t    buf_wdata;
    ifu_buf_entry_t    buf_head;
    logic [BW-1:0]     buf_count;
    logic              buf_empty;

    // PCs of requests in flight, popped in order as responses return.
    ifu_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (issue),
        .wdata (bus.pcg_pc),
        .pop   (rsp_fire),
        .rdata (rsp_pc),
        .count (pcf_count)
    );

    // Instruction buffer toward IR; a flush empties it.
    ifu_sync_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (rsp_keep),
        .wdata (buf_wdata),
        .pop   (ir_pop),
        .rdata (buf_head),
        .count (buf_count)
    );

    // Issue, response and IR-side decisions plus counter and state next values.
    always_comb begin
        flush     = bus.exe_flush | bus.int_flush;
        // A response with nothing in flight (e.g. straight after reset) is ignored.
        rsp_fire  = bus.mem_rsp_vld & (pcf_count != '0);
        // Every in-flight request must already own a buffer slot, so the buffer cannot overflow.
        credit_ok = (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                    ((32'(outstanding_q) + 32'(buf_count)) < 32'(BUF_DEPTH));

        bus.mem_req_vld  = bus.pcg_req_vld & (state_q == ST_RUN) & ~flush & credit_ok;
        bus.mem_req_addr = bus.pcg_pc;
        issue            = bus.mem_req_vld & bus.mem_req_rdy;
        bus.pcg_accept   = issue;

        rsp_keep         = rsp_fire & (kill_q == '0) & ~flush;
        buf_wdata.instr  = bus.mem_rsp_data;
        buf_wdata.pc     = IFU_ADDR_W'(rsp_pc);
        buf_wdata.err    = bus.mem_rsp_err;

        buf_empty        = (buf_count == '0);
        ir_pop           = ~buf_empty & bus.ir_rdy & ~flush;

        outstanding_d    = outstanding_q + OW'(issue) - OW'(rsp_fire);

        kill_d = kill_q;
        if (flush) begin
            // Everything still in flight after this cycle belongs to the old stream.
            kill_d = outstanding_q - OW'(rsp_fire);
        end else if (rsp_fire && (kill_q != '0)) begin
            kill_d = kill_q - 1'b1;
        end

        state_d = state_q;
        if (flush) begin
            state_d = (kill_d != '0) ? ST_KILL : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN:  if (rsp_keep && bus.mem_rsp_err) state_d = ST_HALT;
                ST_KILL: if (kill_d == '0) state_d = ST_RUN;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, outstanding-request count and kill count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    // IR outputs show the buffer head, forced to zero while the buffer is empty.
    always_comb begin
        bus.ir_vld   = ~buf_empty;
        bus.ir_instr = buf_empty ? '0 : buf_head.instr;
        bus.ir_pc    = buf_empty ? '0 : ADDR_W'(buf_head.pc);
        bus.ir_err   = buf_empty ? 1'b0 : buf_head.err;
    end

    assign dbg_state       = state_q;
    assign dbg_outstanding = outstanding_q;
    assign dbg_kill_cnt    = kill_q;

endmodule
